// File: rtl/johnson_counter_n.sv
// Parametrised Johnson (twisted-ring) counter with direction control, legality-checked
// parallel load, binary position index, one-hot phase decode and wrap/load-error pulses.
module johnson_counter_n #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  output logic [WIDTH-1:0]     q,
  output logic [IDX_W-1:0]     idx,
  output logic [2*WIDTH-1:0]   phase,
  output logic                 wrap,
  output logic                 load_err
);

  logic [WIDTH-1:0]   r_q;
  logic               r_wrap;
  logic               r_load_err;

  logic [WIDTH-1:0]   w_inv;
  logic               w_legal;
  logic               w_at_zero;
  logic               w_at_last;
  logic [IDX_W-1:0]   w_pop;
  logic [IDX_W-1:0]   w_idx;
  logic [2*WIDTH-1:0] w_phase;

  // Legal codes are 2^k-1 (ones from the LSB) or the complement of such a value (ones from the MSB).
  assign w_inv     = ~load_value;
  assign w_legal   = ((load_value & (load_value + WIDTH'(1))) == '0) ||
                     ((w_inv & (w_inv + WIDTH'(1))) == '0);
  assign w_at_zero = (r_q == '0);
  assign w_at_last = (r_q == {1'b1, {(WIDTH-1){1'b0}}});

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + IDX_W'(r_q[i]);
    end
    // Modulo-2^IDX_W subtraction keeps this correct when 2*WIDTH == 2**IDX_W.
    if (r_q[0] || w_at_zero) w_idx = w_pop;
    else                     w_idx = IDX_W'(2*WIDTH) - w_pop;
  end

  always_comb begin
    w_phase = '0;
    for (int unsigned k = 0; k < 2*WIDTH; k++) begin
      w_phase[k] = (w_idx == IDX_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q        <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_wrap <= 1'b0;
      if (w_legal) begin
        r_q        <= load_value;
        r_load_err <= 1'b0;
      end else begin
        r_q        <= '0;
        r_load_err <= 1'b1;
      end
    end else begin
      r_load_err <= 1'b0;
      if (en) begin
        if (up) begin
          r_q    <= {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
          r_wrap <= w_at_last;
        end else begin
          r_q    <= {~r_q[0], r_q[WIDTH-1:1]};
          r_wrap <= w_at_zero;
        end
      end else begin
        r_wrap <= 1'b0;
      end
    end
  end

  assign q        = r_q;
  assign idx      = w_idx;
  assign phase    = w_phase;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule
